// File: rtl/event_pulse_generator.sv
// Event pulse generator: queues single-cycle event requests in a saturating
// counter and replays each one as a clean high/low pulse on o_Data, sized so
// a remote 2-flop synchroniser plus rising-edge detector sees every event once.
module event_pulse_generator #(
  parameter int unsigned HIGH_CYCLES = 2,
  parameter int unsigned LOW_CYCLES  = 3,
  parameter int unsigned PEND_W      = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_Event,
  input  logic              i_Enable,
  input  logic              i_Clr_Ovf,
  output logic              o_Data,
  output logic              o_Busy,
  output logic [PEND_W-1:0] o_Pending,
  output logic              o_Overflow
);

  // Configuration guard: widths outside 2..255 break the detector contract.
  if (HIGH_CYCLES < 2 || HIGH_CYCLES > 255 || LOW_CYCLES < 2 || LOW_CYCLES > 255 ||
      PEND_W < 1) begin : g_param_err
    $fatal(1, "event_pulse_generator: parameter out of range");
  end

  typedef enum logic [1:0] {StIdle, StHigh, StLow} state_e;

  localparam logic [7:0]        HighLast = 8'(HIGH_CYCLES - 1);
  localparam logic [7:0]        LowLast  = 8'(LOW_CYCLES - 1);
  localparam logic [PEND_W-1:0] PendMax  = '1;

  state_e            state_q, state_d;
  logic [7:0]        cnt_q, cnt_d;
  logic              data_q, data_d;
  logic              busy_q, busy_d;
  logic [PEND_W-1:0] pend_q, pend_d;
  logic              ovf_q, ovf_d;
  logic              can_launch;
  logic              launch;
  logic              drop;

  assign can_launch = (pend_q != '0) && i_Enable;

  // Pulse FSM: next state, width counter and line level.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    launch  = 1'b0;
    unique case (state_q)
      StIdle: begin
        data_d = 1'b0;
        if (can_launch) begin
          launch  = 1'b1;
          state_d = StHigh;
          cnt_d   = 8'd0;
          data_d  = 1'b1;
        end
      end
      StHigh: begin
        if (cnt_q == HighLast) begin
          state_d = StLow;
          cnt_d   = 8'd0;
          data_d  = 1'b0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      StLow: begin
        if (cnt_q == LowLast) begin
          cnt_d = 8'd0;
          // Chain straight into the next pulse when more work is queued.
          if (can_launch) begin
            launch  = 1'b1;
            state_d = StHigh;
            data_d  = 1'b1;
          end else begin
            state_d = StIdle;
            data_d  = 1'b0;
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = 8'd0;
        data_d  = 1'b0;
      end
    endcase
    busy_d = (state_d != StIdle);
  end

  // Pending counter and sticky overflow; a coincident inc/dec nets to zero.
  always_comb begin
    pend_d = pend_q;
    drop   = 1'b0;
    if (i_Event && !launch) begin
      if (pend_q == PendMax) begin
        drop = 1'b1;
      end else begin
        pend_d = pend_q + 1'b1;
      end
    end else if (!i_Event && launch) begin
      pend_d = pend_q - 1'b1;
    end
    ovf_d = ovf_q;
    if (i_Clr_Ovf) begin
      ovf_d = 1'b0;
    end
    if (drop) begin
      ovf_d = 1'b1;
    end
  end

  // State register with asynchronous clear of everything.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= 8'd0;
      data_q  <= 1'b0;
      busy_q  <= 1'b0;
      pend_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      busy_q  <= busy_d;
      pend_q  <= pend_d;
      ovf_q   <= ovf_d;
    end
  end

  assign o_Data     = data_q;
  assign o_Busy     = busy_q;
  assign o_Pending  = pend_q;
  assign o_Overflow = ovf_q;

endmodule

// File: tb/tb_event_pulse_generator.sv
// Bench for event_pulse_generator: stimulus pushes the expected rising-edge
// positions of each pulse; a monitor pops them as pulses appear on o_Data.
module tb_event_pulse_generator;

  localparam int unsigned HighCycles = 2;
  localparam int unsigned LowCycles  = 3;
  localparam int unsigned PendW      = 4;

  logic             clk;
  logic             reset;
  logic             i_Event;
  logic             i_Enable;
  logic             i_Clr_Ovf;
  logic             o_Data;
  logic             o_Busy;
  logic [PendW-1:0] o_Pending;
  logic             o_Overflow;

  int n_checks = 0;
  int n_pass   = 0;
  int edge_n   = 0;
  int exp_rise[$];
  int e0;
  int e1;

  event_pulse_generator #(
    .HIGH_CYCLES(HighCycles),
    .LOW_CYCLES (LowCycles),
    .PEND_W     (PendW)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .i_Event   (i_Event),
    .i_Enable  (i_Enable),
    .i_Clr_Ovf (i_Clr_Ovf),
    .o_Data    (o_Data),
    .o_Busy    (o_Busy),
    .o_Pending (o_Pending),
    .o_Overflow(o_Overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Index of the most recent rising clock edge.
  always @(posedge clk) edge_n <= edge_n + 1;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic wait_edge(input int n);
    while (edge_n < n) @(negedge clk);
  endtask

  // Monitor: every rising edge of o_Data must match the next queued position,
  // and every completed pulse must be exactly HighCycles wide.
  initial begin
    logic prev_data;
    int   hi_len;
    int   exp;
    prev_data = 1'b0;
    hi_len    = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        prev_data = 1'b0;
        hi_len    = 0;
      end else begin
        if (o_Data && !prev_data) begin
          hi_len = 1;
          if (exp_rise.size() == 0) begin
            n_checks++;
            $display("FAIL unexpected_pulse: rise after edge %0d, none expected", edge_n);
          end else begin
            exp = exp_rise.pop_front();
            check("pulse_rise_edge", edge_n, exp);
          end
        end else if (o_Data) begin
          hi_len++;
        end else if (prev_data) begin
          check("pulse_high_width", hi_len, int'(HighCycles));
        end
        prev_data = o_Data;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, edge %0d", edge_n);
    $fatal(1, "watchdog");
  end

  initial begin
    reset     = 1'b1;
    i_Event   = 1'b0;
    i_Enable  = 1'b1;
    i_Clr_Ovf = 1'b0;
    #2;
    check("rst_data", int'(o_Data), 0);
    check("rst_busy", int'(o_Busy), 0);
    check("rst_pend", int'(o_Pending), 0);
    check("rst_ovf", int'(o_Overflow), 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Single event: pulse rises on the edge after the request.
    i_Event = 1'b1;
    e0 = edge_n + 1;
    exp_rise.push_back(e0 + 1);
    @(negedge clk);
    i_Event = 1'b0;
    check("t1_pend_after_event", int'(o_Pending), 1);
    @(negedge clk);
    check("t1_pend_after_launch", int'(o_Pending), 0);
    check("t1_data_high", int'(o_Data), 1);
    wait_edge(e0 + 3);
    check("t1_data_low", int'(o_Data), 0);
    wait_edge(e0 + 5);
    check("t1_busy_in_low", int'(o_Busy), 1);
    wait_edge(e0 + 6);
    check("t1_busy_idle", int'(o_Busy), 0);

    // Three back-to-back events: pulses every HIGH+LOW clocks, no idle gap.
    e0 = edge_n + 1;
    exp_rise.push_back(e0 + 1);
    exp_rise.push_back(e0 + 6);
    exp_rise.push_back(e0 + 11);
    for (int i = 0; i < 3; i++) begin
      i_Event = 1'b1;
      @(negedge clk);
      check("t2_pend_seq", int'(o_Pending), (i == 2) ? 2 : 1);
    end
    i_Event = 1'b0;
    wait_edge(e0 + 5);
    check("t2_busy_gap", int'(o_Busy), 1);
    check("t2_data_gap", int'(o_Data), 0);
    wait_edge(e0 + 6);
    check("t2_pend_mid", int'(o_Pending), 1);
    wait_edge(e0 + 11);
    check("t2_pend_last", int'(o_Pending), 0);
    wait_edge(e0 + 16);
    check("t2_busy_idle", int'(o_Busy), 0);

    // Disabled queue fills to 15 and drops the 16th event.
    i_Enable = 1'b0;
    i_Event  = 1'b1;
    repeat (16) @(negedge clk);
    i_Event = 1'b0;
    check("t3_pend_full", int'(o_Pending), 15);
    check("t3_ovf_set", int'(o_Overflow), 1);
    check("t3_data_quiet", int'(o_Data), 0);
    i_Enable = 1'b1;
    e0 = edge_n + 1;
    for (int k = 0; k < 15; k++) exp_rise.push_back(e0 + 5 * k);
    wait_edge(e0 + 70);
    check("t3_pend_drained", int'(o_Pending), 0);
    wait_edge(e0 + 75);
    check("t3_busy_idle", int'(o_Busy), 0);

    // Full queue: overflow set beats clear; inc coincident with launch holds.
    i_Enable = 1'b0;
    i_Event  = 1'b1;
    repeat (15) @(negedge clk);
    i_Event = 1'b0;
    check("t4_pend_full", int'(o_Pending), 15);
    i_Clr_Ovf = 1'b1;
    @(negedge clk);
    i_Clr_Ovf = 1'b0;
    check("t4_ovf_cleared", int'(o_Overflow), 0);
    i_Event   = 1'b1;
    i_Clr_Ovf = 1'b1;
    @(negedge clk);
    i_Event   = 1'b0;
    i_Clr_Ovf = 1'b0;
    check("t4_ovf_set_wins", int'(o_Overflow), 1);
    check("t4_pend_sat", int'(o_Pending), 15);
    i_Clr_Ovf = 1'b1;
    @(negedge clk);
    i_Clr_Ovf = 1'b0;
    check("t4_ovf_cleared2", int'(o_Overflow), 0);
    i_Enable = 1'b1;
    i_Event  = 1'b1;
    e0 = edge_n + 1;
    for (int k = 0; k < 16; k++) exp_rise.push_back(e0 + 5 * k);
    @(negedge clk);
    i_Event = 1'b0;
    check("t4_pend_inc_dec", int'(o_Pending), 15);
    check("t4_ovf_no_drop", int'(o_Overflow), 0);
    check("t4_data_launch", int'(o_Data), 1);
    wait_edge(e0 + 75);
    check("t4_pend_drained", int'(o_Pending), 0);
    wait_edge(e0 + 80);
    check("t4_busy_idle", int'(o_Busy), 0);

    // Reset mid-pulse with events still queued.
    i_Enable = 1'b0;
    i_Event  = 1'b1;
    repeat (4) @(negedge clk);
    i_Event = 1'b0;
    check("t5_pend_setup", int'(o_Pending), 4);
    i_Enable = 1'b1;
    e0 = edge_n + 1;
    exp_rise.push_back(e0);
    @(negedge clk);
    check("t5_data_high", int'(o_Data), 1);
    check("t5_pend_3", int'(o_Pending), 3);
    #2;
    reset = 1'b1;
    #1;
    check("t5_rst_data", int'(o_Data), 0);
    check("t5_rst_busy", int'(o_Busy), 0);
    check("t5_rst_pend", int'(o_Pending), 0);
    check("t5_rst_ovf", int'(o_Overflow), 0);
    @(negedge clk);
    #2;
    reset = 1'b0;
    repeat (15) @(negedge clk);
    check("t5_pend_after", int'(o_Pending), 0);
    check("t5_busy_after", int'(o_Busy), 0);

    // Disable during the first HIGH cycle: pulse completes, then parks.
    i_Enable = 1'b0;
    i_Event  = 1'b1;
    repeat (2) @(negedge clk);
    i_Event  = 1'b0;
    i_Enable = 1'b1;
    e0 = edge_n + 1;
    exp_rise.push_back(e0);
    @(negedge clk);
    i_Enable = 1'b0;
    check("t6_pend_1", int'(o_Pending), 1);
    wait_edge(e0 + 1);
    check("t6_data_still_high", int'(o_Data), 1);
    wait_edge(e0 + 4);
    check("t6_busy_low_phase", int'(o_Busy), 1);
    wait_edge(e0 + 5);
    check("t6_busy_parked", int'(o_Busy), 0);
    check("t6_pend_held", int'(o_Pending), 1);
    repeat (3) @(negedge clk);
    check("t6_pend_still_held", int'(o_Pending), 1);
    i_Enable = 1'b1;
    e1 = edge_n + 1;
    exp_rise.push_back(e1);
    wait_edge(e1 + 5);
    check("t6_pend_done", int'(o_Pending), 0);
    check("t6_busy_done", int'(o_Busy), 0);

    repeat (5) @(negedge clk);
    check("missing_pulses", exp_rise.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
